// File: rtl/johnson_seg_decoder.sv
// Johnson-coded segment receiver: synchronizes a twisted-ring code, recovers its phase and tracks
// step direction, errors, lock and a signed step count. Define GLITCH_FILTER_EN to require a stable code.
module johnson_seg_decoder #(
    parameter int unsigned WIDTH       = 6,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_COUNT  = 4,
    parameter int unsigned CNT_W       = 8,
    localparam int unsigned PW         = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] seg_in,
    input  logic             clr_count,
    output logic [PW-1:0]    phase,
    output logic             phase_valid,
    output logic             step_fwd,
    output logic             step_rev,
    output logic             code_err,
    output logic             locked,
    output logic [CNT_W-1:0] step_count
);

    localparam int unsigned NPH = 2 * WIDTH;

    typedef enum logic [1:0] {StIdle, StTrack, StLock} state_t;

    state_t           state_q;
    logic [3:0]       lcnt_q;
    logic             dir_q;
    logic [WIDTH-1:0] last_q;
    logic             primed_q;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] s_inv;
    logic             stable;
    logic             evt;
    logic             dec_valid;
    logic [PW-1:0]    dec_phase;
    logic             is_fwd;
    logic             is_rev;
    logic             fwd_ev;
    logic             rev_ev;
    logic [3:0]       run_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= seg_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

`ifdef GLITCH_FILTER_EN
    logic [WIDTH-1:0] s_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s_prev_q <= '0;
        else        s_prev_q <= s;
    end

    assign stable = (s == s_prev_q);
`else
    assign stable = 1'b1;
`endif

    function automatic logic [PW-1:0] inc_ph(input logic [PW-1:0] p);
        return (32'(p) == NPH - 1) ? '0 : p + 1'b1;
    endfunction

    // Upper half of the ring is the complement of a low-ones run.
    always_comb begin
        s_inv = ~s;
        if (s[WIDTH-1]) begin
            dec_valid = ((s_inv & (s_inv + 1'b1)) == '0);
            dec_phase = PW'(NPH - $countones(s));
        end else begin
            dec_valid = ((s & (s + 1'b1)) == '0);
            dec_phase = PW'($countones(s));
        end
    end

    assign evt      = ena && stable && (!primed_q || (s != last_q));
    assign is_fwd   = (dec_phase == inc_ph(phase));
    assign is_rev   = (phase == inc_ph(dec_phase));
    assign fwd_ev   = evt && dec_valid && (state_q != StIdle) && is_fwd;
    assign rev_ev   = evt && dec_valid && (state_q != StIdle) && !is_fwd && is_rev;
    assign run_next = (is_fwd == dir_q) ? lcnt_q + 4'd1 : 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            lcnt_q      <= '0;
            dir_q       <= 1'b0;
            last_q      <= '0;
            primed_q    <= 1'b0;
            phase       <= '0;
            phase_valid <= 1'b0;
            step_fwd    <= 1'b0;
            step_rev    <= 1'b0;
            code_err    <= 1'b0;
            locked      <= 1'b0;
        end else begin
            step_fwd <= fwd_ev;
            step_rev <= rev_ev;
            code_err <= 1'b0;
            if (evt) begin
                last_q   <= s;
                primed_q <= 1'b1;
                if (!dec_valid) begin
                    code_err    <= 1'b1;
                    phase_valid <= 1'b0;
                    lcnt_q      <= '0;
                    locked      <= 1'b0;
                    state_q     <= StIdle;
                end else if (state_q == StIdle) begin
                    phase       <= dec_phase;
                    phase_valid <= 1'b1;
                    lcnt_q      <= '0;
                    state_q     <= StTrack;
                end else if (fwd_ev || rev_ev) begin
                    phase <= dec_phase;
                    dir_q <= is_fwd;
                    if (state_q == StLock) begin
                        if (is_fwd != dir_q) begin
                            lcnt_q  <= 4'd1;
                            locked  <= 1'b0;
                            state_q <= StTrack;
                        end
                    end else begin
                        lcnt_q <= run_next;
                        if (32'(run_next) >= LOCK_COUNT) begin
                            locked  <= 1'b1;
                            state_q <= StLock;
                        end
                    end
                end else begin
                    // Valid code more than one phase away: resynchronize on it.
                    code_err <= 1'b1;
                    phase    <= dec_phase;
                    lcnt_q   <= '0;
                    locked   <= 1'b0;
                    state_q  <= StTrack;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         step_count <= '0;
        else if (clr_count) step_count <= '0;
        else if (fwd_ev)    step_count <= step_count + 1'b1;
        else if (rev_ev)    step_count <= step_count - 1'b1;
    end

endmodule
